// File: rtl/ascon_sbox_layer.sv
// Sequential ASCON substitution layer p_s.
// COLS_PER_CYCLE columns of the 320-bit state are substituted per clock.
// A full pass takes 64/COLS_PER_CYCLE RUN cycles, then one DONE cycle.
// The state register is the output and holds its value while idle.

// One 5-bit ASCON sbox column, written as the bitsliced boolean network.
// x_i = {x0,x1,x2,x3,x4} with x0 as the MSB; y_o uses the same packing.
module ascon_sbox_col (
  input  logic [4:0] x_i,
  output logic [4:0] y_o
);
  logic a0, a1, a2, a3, a4;
  logic b0, b1, b2, b3, b4;

  // input xor stage
  assign a0 = x_i[4] ^ x_i[0];
  assign a1 = x_i[3];
  assign a2 = x_i[2] ^ x_i[3];
  assign a3 = x_i[1];
  assign a4 = x_i[0] ^ x_i[1];

  // chi-like nonlinear stage
  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  // output xor stage and the final inversion of x2
  assign y_o = {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};
endmodule

module ascon_sbox_layer #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);
  localparam int P       = COLS_PER_CYCLE;
  localparam int NGROUPS = 64 / P;
  localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int LOGP    = $clog2(P);
  localparam logic [CW-1:0] LAST = CW'(NGROUPS - 1);

  generate
    if (!(P == 1 || P == 2 || P == 4 || P == 8 || P == 16 || P == 32 || P == 64)) begin : g_bad_p
      $error("ascon_sbox_layer: COLS_PER_CYCLE must be a power of two in 1..64");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [319:0]      st_q, st_d;

  logic [5:0]        base;
  logic [P-1:0][5:0] col_idx;
  logic [P-1:0][4:0] sb_in;
  logic [P-1:0][4:0] sb_out;

  // First column of the current group; P is a power of two so this is a shift.
  assign base = 6'(cnt_q) << LOGP;

  // Gather the P columns of the current group from the state register.
  always_comb begin
    col_idx = '0;
    sb_in   = '0;
    for (int k = 0; k < P; k++) begin
      col_idx[k] = base + 6'(k);
      sb_in[k]   = {st_q[{3'd4, col_idx[k]}], st_q[{3'd3, col_idx[k]}],
                    st_q[{3'd2, col_idx[k]}], st_q[{3'd1, col_idx[k]}],
                    st_q[{3'd0, col_idx[k]}]};
    end
  end

  generate
    for (genvar k = 0; k < P; k++) begin : g_col
      ascon_sbox_col u_col (
        .x_i (sb_in[k]),
        .y_o (sb_out[k])
      );
    end
  endgenerate

  // Next-state: load on start, scatter sbox images back during RUN, count groups.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (start_i) begin
          st_d  = state_i;
          cnt_d = '0;
          fsm_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int k = 0; k < P; k++) begin
          st_d[{3'd4, col_idx[k]}] = sb_out[k][4];
          st_d[{3'd3, col_idx[k]}] = sb_out[k][3];
          st_d[{3'd2, col_idx[k]}] = sb_out[k][2];
          st_d[{3'd1, col_idx[k]}] = sb_out[k][1];
          st_d[{3'd0, col_idx[k]}] = sb_out[k][0];
        end
        if (cnt_q == LAST) begin
          fsm_d = S_DONE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset aborts any pass in flight.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q <= S_IDLE;
      cnt_q <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  assign state_o = st_q;
  assign busy_o  = (fsm_q != S_IDLE);
  assign done_o  = (fsm_q == S_DONE);
endmodule
